// File: rtl/dmem_responder.sv
// ============================================================================
// Module   : dmem_responder
// Brief    : Multi-cycle data-memory responder for the core's M-stage
//            load/store port. Optional out-of-range error port: DMEM_ERR_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        isLdM,
  input  logic        isStM,
  input  logic [31:0] addrM,
  input  logic [31:0] stDataM,
  output logic [31:0] ldResultM,
  output logic        ldValid,
  output logic        stall
`ifdef DMEM_ERR_EN
  ,
  output logic        err
`endif
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int C_CNT_INIT = (LATENCY > 1) ? (LATENCY - 2) : 0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state, w_nextState;
  logic [CNT_W-1:0]   r_cnt, w_nextCnt;
  logic               r_isLd, r_isSt;
  logic [ADDR_W-1:0]  r_idx;
  logic [31:0]        r_data;
  logic [31:0]        r_ldResult;
  logic [31:0]        r_mem [0:DEPTH-1];

  logic               w_req, w_inIdle, w_accept, w_enterDone;
  logic               w_selLd, w_selSt, w_selOor;
  logic [ADDR_W-1:0]  w_selIdx;
  logic [31:0]        w_selData;

  assign w_req    = isLdM | isStM;
  assign w_inIdle = (r_state == S_IDLE);
  assign w_accept = w_inIdle & w_req;

`ifdef DMEM_ERR_EN
  logic w_inOor, r_oor;
  assign w_inOor  = ({2'b00, addrM[31:2]} >= 32'(DEPTH));
  assign w_selOor = w_inIdle ? w_inOor : r_oor;
  assign err      = (r_state == S_DONE) & r_oor;
`else
  assign w_selOor = 1'b0;
`endif

  // With LATENCY==1 DONE is entered straight from IDLE, before capture lands.
  assign w_selLd   = w_inIdle ? (isLdM & ~isStM) : r_isLd;
  assign w_selSt   = w_inIdle ? isStM : r_isSt;
  assign w_selIdx  = w_inIdle ? addrM[ADDR_W+1:2] : r_idx;
  assign w_selData = w_inIdle ? stDataM : r_data;

  always_comb begin
    w_nextState = r_state;
    w_nextCnt   = r_cnt;
    unique case (r_state)
      S_IDLE: begin
        if (w_req) begin
          if (LATENCY == 1) begin
            w_nextState = S_DONE;
          end else begin
            w_nextState = S_WAIT;
            w_nextCnt   = CNT_W'(C_CNT_INIT);
          end
        end
      end
      S_WAIT: begin
        if (r_cnt == '0) w_nextState = S_DONE;
        else             w_nextCnt   = r_cnt - 1'b1;
      end
      S_DONE:  w_nextState = S_IDLE;
      default: w_nextState = S_IDLE;
    endcase
  end

  assign w_enterDone = (r_state != S_DONE) & (w_nextState == S_DONE);
  assign stall       = w_accept | (r_state == S_WAIT);
  assign ldValid     = (r_state == S_DONE) & r_isLd;
  assign ldResultM   = r_ldResult;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_isLd     <= 1'b0;
      r_isSt     <= 1'b0;
      r_idx      <= '0;
      r_data     <= '0;
      r_ldResult <= '0;
`ifdef DMEM_ERR_EN
      r_oor      <= 1'b0;
`endif
    end else begin
      r_state <= w_nextState;
      r_cnt   <= w_nextCnt;
      if (w_accept) begin
        r_isLd <= isLdM & ~isStM;
        r_isSt <= isStM;
        r_idx  <= addrM[ADDR_W+1:2];
        r_data <= stDataM;
`ifdef DMEM_ERR_EN
        r_oor  <= w_inOor;
`endif
      end
      if (w_enterDone && w_selLd) begin
        r_ldResult <= w_selOor ? 32'h0 : r_mem[w_selIdx];
      end
    end
  end

  // Array is not reset; a store whose completing edge sees reset is dropped.
  always_ff @(posedge clk) begin
    if (!reset && w_enterDone && w_selSt && !w_selOor) begin
      r_mem[w_selIdx] <= w_selData;
    end
  end

endmodule

`default_nettype wire

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder on the far end of the core's memory-stage load/store interface.
- Accepts one load or store per transaction from the M stage (`isLdM`/`isStM`, address = `aluResultM`, store data = `op2M`) and serves it with a configurable multi-cycle latency.
- Drives the `stall` back to the core while busy, then returns the load result with a one-cycle valid pulse.

Parameters:
- DEPTH, 256, number of 32-bit words; power of two ≥ 4; ADDR_W = log2(DEPTH).
- LATENCY, 2, stall cycles per transaction; integer ≥ 1.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- isLdM  input  1  load request from M stage
- isStM  input  1  store request from M stage
- addrM  input  32  byte address (`aluResultM`)
- stDataM  input  32  store data (`op2M`)
- ldResultM  output  32  load data, registered
- ldValid  output  1  one-cycle pulse: `ldResultM` updated
- stall  output  1  core must hold M stage while high
- err  output  1  out-of-range pulse; present only with DMEM_ERR_EN

Behaviour:
- Storage: DEPTH×32 array, word index = `addrM[ADDR_W+1:2]`; `addrM[1:0]` ignored; array not cleared by reset.
- req = `isLdM | isStM`. If both are high, the transaction is a store and `ldValid` stays 0.
- FSM states: IDLE, WAIT, DONE.
  - IDLE with req: capture op/addr/data.
    - LATENCY==1 → DONE.
    - Otherwise → WAIT with cnt = LATENCY-2.
  - IDLE without req: stay in IDLE.
  - WAIT: if cnt==0 → DONE, else cnt−1.
  - DONE: inputs ignored (the core still presents the same request this cycle); → IDLE unconditionally.
- stall = (IDLE & req) | WAIT. Combinational, so it is high in the request's first cycle.
- For a request first presented in cycle N:
  - `stall` is high in cycles N..N+LATENCY-1 and low in N+LATENCY (DONE).
  - Array access happens on the edge entering DONE:
    - Store writes the captured data.
    - Load registers `mem[idx]` into `ldResultM`.
  - In DONE, `ldValid` = 1 for a load, 0 for a store.
  - `ldResultM` holds its value until the next load completes; stores never change it.
- Back-to-back: the earliest next acceptance is cycle N+LATENCY+1, so throughput is one transaction per LATENCY+1 cycles.
- Captured address/data are used throughout; input changes during WAIT have no effect.
- Reset (any state, including mid-transaction):
  - State → IDLE, cnt = 0, `ldResultM` = 0, `ldValid` = 0, `err` = 0.
  - A pending store is dropped (no write).
  - `stall` follows the IDLE equation in the next cycle.
- cnt width = max(1, clog2(LATENCY)).

Optional Feature:
- Macro: DMEM_ERR_EN.
- Defined:
  - A transaction with `addrM[31:2]` ≥ DEPTH is out of range.
  - Store: dropped.
  - Load: returns `ldResultM` = 0 with `ldValid` = 1.
  - `err` pulses high in the DONE cycle. Otherwise `err` = 0; reset value 0.
  - Stall timing is unchanged.
- Undefined: no `err` port; high address bits are discarded, so the index wraps modulo DEPTH.

Test Plan (DEPTH=256, LATENCY=2):
1. Reset held 2 cycles, no requests → `stall` = 0, `ldValid` = 0, `ldResultM` = 0x00000000.
2. Store 0xDEADBEEF to 0x10, then load 0x10 → `stall` high 2 cycles for each; in the load's 3rd cycle `ldResultM` = 0xDEADBEEF and `ldValid` = 1 for exactly one cycle.
3. Store 0x1 to 0x14 with the request held through DONE and one extra cycle → second acceptance starts in cycle 4 (`stall` high again); load 0x14 → 0x1.
4. `isLdM` = `isStM` = 1, addr 0x20, data 5 → `ldValid` stays 0; subsequent load 0x20 → 5.
5. Store 1 to 0x30; then store 7 to 0x30 with reset asserted in its WAIT cycle → load 0x30 returns 1, and `stall` is low the cycle after reset.
6. Out-of-range access, addr 0x400 (index 256):
   - With DMEM_ERR_EN: store 9 is dropped and `err` pulses; load 0x400 → 0 with `err` pulse; load 0x0 is unaffected.
   - Without DMEM_ERR_EN: store 9 to 0x400, then load 0x0 → 9.
